seg_mux_driver: RTL



---
 rtl/seg_mux_driver.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/seg_mux_driver.sv
// Time-multiplexed hex 7-segment driver with per-digit store, PWM brightness and polarity control.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module seg_mux_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_LOG2   = 16,
    parameter int BRIGHT_W       = 3,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEL_W          = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   load,
    input  logic [4*NUM_DIGITS-1:0] val,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [BRIGHT_W-1:0]     bright,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [SEL_W-1:0]        digit_idx
);

    localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW != 0}};
    localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
    localparam logic [SEL_W-1:0]      SEL_LAST = SEL_W'(NUM_DIGITS - 1);

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] seg_pol(input logic [6:0] raw);
        return raw ^ SEG_OFF;
    endfunction

    function automatic logic dp_pol(input logic raw);
        return raw ^ DP_OFF;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] an_pol(input logic [NUM_DIGITS-1:0] raw);
        return raw ^ AN_OFF;
    endfunction

    logic [REFRESH_LOG2-1:0] prescaler_p0;
    logic [SEL_W-1:0]        sel_p0;
    logic [3:0]              value_p0 [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   dpreg_p0;

    logic [6:0]              seg_p1;
    logic                    dp_p1;
    logic [NUM_DIGITS-1:0]   an_p1;
    logic [SEL_W-1:0]        idx_p1;

    logic [BRIGHT_W-1:0]     ph;
    logic                    lit;
    logic                    show_seg;
    logic                    show_an;
    logic [NUM_DIGITS-1:0]   an_raw;
    logic [6:0]              seg_nx;
    logic                    dp_nx;
    logic [NUM_DIGITS-1:0]   an_nx;

    assign ph  = prescaler_p0[REFRESH_LOG2-1 -: BRIGHT_W];
    assign lit = (ph <= bright) && !blank[sel_p0];

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] suppress;
    logic                  upper_zero;

    // A digit is a leading zero when it and every higher digit hold 0.
    always_comb begin
        suppress   = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero  = upper_zero && (value_p0[i] == 4'd0);
            suppress[i] = upper_zero;
        end
    end
`endif

    always_comb begin
        seg_nx   = SEG_OFF;
        dp_nx    = DP_OFF;
        an_nx    = AN_OFF;
        show_seg = 1'b1;
        show_an  = 1'b1;
        an_raw   = '0;
        an_raw[sel_p0] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (suppress[sel_p0]) begin
            show_seg = 1'b0;
            show_an  = dpreg_p0[sel_p0];
        end
`endif
        if (lit && show_an) begin
            an_nx = an_pol(an_raw);
            dp_nx = dp_pol(dpreg_p0[sel_p0]);
            if (show_seg) begin
                seg_nx = seg_pol(hex_decode(value_p0[sel_p0]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_p0 <= '0;
            sel_p0       <= '0;
            dpreg_p0     <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                value_p0[i] <= 4'd0;
            end
            seg_p1 <= SEG_OFF;
            dp_p1  <= DP_OFF;
            an_p1  <= AN_OFF;
            idx_p1 <= '0;
        end else begin
            // Stage p0: scan counters and digit store
            prescaler_p0 <= prescaler_p0 + 1'b1;
            if (&prescaler_p0) begin
                sel_p0 <= (sel_p0 == SEL_LAST) ? '0 : sel_p0 + 1'b1;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (load[i]) begin
                    value_p0[i] <= val[4*i +: 4];
                    dpreg_p0[i] <= dp_in[i];
                end
            end
            // Stage p1: registered pin drivers, one cycle behind p0
            seg_p1 <= seg_nx;
            dp_p1  <= dp_nx;
            an_p1  <= an_nx;
            idx_p1 <= sel_p0;
        end
    end

    assign seg       = seg_p1;
    assign dp        = dp_p1;
    assign an        = an_p1;
    assign digit_idx = idx_p1;

endmodule
